// File: rtl/dtm_dbus_bridge.sv
// rtl/dtm_dbus_bridge.sv - DTM request/response to debug-module register access bridge
// Optional ACCESS timeout enabled by defining DTM_DBUS_BRIDGE_TIMEOUT_EN.
module dtm_dbus_bridge #(
    parameter int DEBUG_DATA_BITS = 34,
    parameter int DEBUG_ADDR_BITS = 5,
    parameter int DEBUG_OP_BITS   = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                                                 clock,
    input  logic                                                 resetn,
    input  logic                                                 dtm_req_valid,
    output logic                                                 dtm_req_ready,
    input  logic [DEBUG_OP_BITS+DEBUG_ADDR_BITS+DEBUG_DATA_BITS-1:0] dtm_req_bits,
    output logic                                                 dtm_resp_valid,
    input  logic                                                 dtm_resp_ready,
    output logic [DEBUG_OP_BITS+DEBUG_DATA_BITS-1:0]             dtm_resp_bits,
    output logic                                                 dm_valid,
    output logic                                                 dm_write,
    output logic [DEBUG_ADDR_BITS-1:0]                           dm_addr,
    output logic [DEBUG_DATA_BITS-1:0]                           dm_wdata,
    input  logic                                                 dm_ready,
    input  logic [DEBUG_DATA_BITS-1:0]                           dm_rdata,
    input  logic                                                 dm_error
);

    localparam logic [DEBUG_OP_BITS-1:0] OP_NOP   = DEBUG_OP_BITS'(0);
    localparam logic [DEBUG_OP_BITS-1:0] OP_READ  = DEBUG_OP_BITS'(1);
    localparam logic [DEBUG_OP_BITS-1:0] OP_WRITE = DEBUG_OP_BITS'(2);
    localparam logic [DEBUG_OP_BITS-1:0] OP_RSVD  = DEBUG_OP_BITS'(3);

    localparam logic [DEBUG_OP_BITS-1:0] RESP_OK      = DEBUG_OP_BITS'(0);
    localparam logic [DEBUG_OP_BITS-1:0] RESP_ERR     = DEBUG_OP_BITS'(2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [DEBUG_OP_BITS-1:0]     op_q, op_d;
    logic [DEBUG_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DEBUG_DATA_BITS-1:0]   wdata_q, wdata_d;
    logic [DEBUG_DATA_BITS-1:0]   resp_data_q, resp_data_d;
    logic [DEBUG_OP_BITS-1:0]     resp_code_q, resp_code_d;

    logic [DEBUG_OP_BITS-1:0]     req_op;
    logic [DEBUG_DATA_BITS-1:0]   req_data;
    logic [DEBUG_ADDR_BITS-1:0]   req_addr;

    assign req_op   = dtm_req_bits[DEBUG_OP_BITS-1:0];
    assign req_data = dtm_req_bits[DEBUG_OP_BITS+DEBUG_DATA_BITS-1:DEBUG_OP_BITS];
    assign req_addr = dtm_req_bits[DEBUG_OP_BITS+DEBUG_DATA_BITS+DEBUG_ADDR_BITS-1:
                                   DEBUG_OP_BITS+DEBUG_DATA_BITS];

`ifdef DTM_DBUS_BRIDGE_TIMEOUT_EN
    localparam logic [DEBUG_OP_BITS-1:0] RESP_TIMEOUT = DEBUG_OP_BITS'(3);
    localparam logic [7:0]               TO_LAST      = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_code_d = resp_code_q;
`ifdef DTM_DBUS_BRIDGE_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dtm_req_valid) begin
                    op_d        = req_op;
                    addr_d      = req_addr;
                    wdata_d     = req_data;
                    resp_data_d = '0;
                    if (req_op == OP_NOP) begin
                        resp_code_d = RESP_OK;
                        state_d     = ST_RESP;
                    end else if (req_op == OP_RSVD) begin
                        resp_code_d = RESP_ERR;
                        state_d     = ST_RESP;
                    end else begin
                        state_d     = ST_ACCESS;
`ifdef DTM_DBUS_BRIDGE_TIMEOUT_EN
                        cnt_d       = 8'd0;
`endif
                    end
                end
            end
            ST_ACCESS: begin
                // A completing dm_ready wins over a timeout expiring in the same cycle.
                if (dm_ready) begin
                    resp_code_d = dm_error ? RESP_ERR : RESP_OK;
                    resp_data_d = (op_q == OP_READ && !dm_error) ? dm_rdata : '0;
                    state_d     = ST_RESP;
                end
`ifdef DTM_DBUS_BRIDGE_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    resp_code_d = RESP_TIMEOUT;
                    resp_data_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_RESP: begin
                if (dtm_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_code_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_code_q <= resp_code_d;
        end
    end

`ifdef DTM_DBUS_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign dtm_req_ready  = (state_q == ST_IDLE);
    assign dm_valid       = (state_q == ST_ACCESS);
    assign dtm_resp_valid = (state_q == ST_RESP);
    assign dtm_resp_bits  = {resp_data_q, resp_code_q};
    assign dm_write       = (op_q == OP_WRITE);
    assign dm_addr        = addr_q;
    assign dm_wdata       = wdata_q;

endmodule
